snake_engine: RTL and testbench

Parametrised successor to the snake game FSM. It owns the snake state: head, body ring buffer, direction, fruit, length and score, plus the game-flow state machine. Collision and fruit-placement scans are sequential, one segment per cycle, so area scales with LEN_MAX and not with comparators. Sits between the input debouncers/tick divider and the VGA renderer. The renderer reads body segments through a random-access port.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/snake_if.sv | 17 +
 rtl/snake_body_ring.sv | 63 ++++++
 rtl/snake_engine.sv | 191 +++++++++++++++++++
 tb/tb_snake_engine.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake engine.
// Direction codes, FSM state codes, the fruit start offset and a turn helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    // S_SEEK samples a fruit candidate, S_SCAN checks it against the body.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_WAIT   = 4'd2,
        S_STEP   = 4'd3,
        S_CHECK  = 4'd4,
        S_COMMIT = 4'd5,
        S_SEEK   = 4'd6,
        S_SCAN   = 4'd7,
        S_OVER   = 4'd8
    } state_t;

    // Initial fruit sits this many columns right of the initial head.
    localparam int FRUIT_OFS = 8;

    // Clockwise turn adds one, counter-clockwise subtracts one, both mod 4.
    function automatic dir_t rotate(input dir_t d, input logic cw);
        return cw ? dir_t'(d + 2'd1) : dir_t'(d - 2'd1);
    endfunction

endpackage

// File: rtl/snake_if.sv
// snake_if: renderer read port of the snake engine.
// Protocol: there is no back-pressure. The renderer drives rd_idx every cycle;
// one cycle later rd_valid says whether that index was below the snake length,
// and when it was, rd_x/rd_y carry that segment. Invalid indices leave rd_x/rd_y
// holding their previous value.
interface snake_if #(
    parameter int COORD_W = 7,
    parameter int LEN_W   = 6
);
    logic [LEN_W-1:0]   rd_idx;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_valid;

    modport master (output rd_idx, input rd_x, input rd_y, input rd_valid);
    modport slave  (input rd_idx, output rd_x, output rd_y, output rd_valid);
endinterface

// File: rtl/snake_body_ring.sv
// snake_body_ring: LEN_MAX-deep ring of packed {x,y} body segments.
// Segment k (0 = head) lives at slot (ptr - k) mod LEN_MAX. One write port
// (by segment index, or advance-and-write-new-head), a combinational scan read
// and a registered renderer read.
module snake_body_ring #(
    parameter int COORD_W = 7,
    parameter int LEN_MAX = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LEN_W-1:0]   wr_seg,
    input  logic               adv,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [LEN_W-1:0]   scan_idx,
    output logic [COORD_W-1:0] scan_x,
    output logic [COORD_W-1:0] scan_y,
    input  logic [LEN_W-1:0]   length,
    input  logic [LEN_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_valid
);
    localparam int PTR_W = $clog2(LEN_MAX);

    logic [2*COORD_W-1:0] mem [LEN_MAX];
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] p,
                                              input logic [LEN_W-1:0] idx);
        return PTR_W'(LEN_W'(p) - idx);
    endfunction

    assign ptr_nxt = ptr + PTR_W'(1);
    assign {scan_x, scan_y} = mem[slot(ptr, scan_idx)];

    // Head pointer moves forward one slot on every committed move.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) ptr <= '0;
        else if (adv) ptr <= ptr_nxt;
    end

    // Segment storage; a new head lands in the slot the pointer moves to.
    always_ff @(posedge clock_25) begin
        if (adv) mem[ptr_nxt] <= {wr_x, wr_y};
        else if (wr_en) mem[slot(ptr, wr_seg)] <= {wr_x, wr_y};
    end

    // Renderer read: registered, holds previous data on out-of-range index.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (rd_idx < length);
            if (rd_idx < length) {rd_x, rd_y} <= mem[slot(ptr, rd_idx)];
        end
    end
endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game state and flow FSM. Collision and fruit-placement
// scans walk the body ring one segment per cycle.
// Build option: define SNAKE_WRAP_EN to wrap the head around grid edges
// instead of ending the game at a wall.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W    = 124,
    parameter int GRID_H    = 81,
    parameter int COORD_W   = 7,
    parameter int LEN_MAX   = 32,
    parameter int LEN_W     = 6,
    parameter int BEGIN_LEN = 4,
    parameter int SCORE_W   = 8
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               game_tik,
    input  logic               start,
    input  logic               turn_left,
    input  logic               turn_right,
    input  logic [COORD_W-1:0] rnd_x,
    input  logic [COORD_W-1:0] rnd_y,
    snake_if.slave             bus,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [COORD_W-1:0] fruit_x,
    output logic [COORD_W-1:0] fruit_y,
    output logic [LEN_W-1:0]   length,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               busy,
    output state_t             state
);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X0     = COORD_W'(GRID_W / 2);
    localparam logic [COORD_W-1:0] Y0     = COORD_W'(GRID_H / 2);
    localparam logic [COORD_W-1:0] FX0    = COORD_W'(GRID_W / 2 + FRUIT_OFS);
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [LEN_W-1:0]   L_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   L_TWO  = LEN_W'(2);
    localparam logic [LEN_W-1:0]   L_FULL = LEN_W'(LEN_MAX);
    localparam logic [LEN_W-1:0]   L_BEG  = LEN_W'(BEGIN_LEN);

    dir_t               dir, dir_nxt;
    logic               turn_pend, turn_cw, tik_pend, eat, wall, off;
    logic [COORD_W-1:0] nx, ny, nh_x, nh_y, cand_x, cand_y;
    logic [COORD_W-1:0] scan_x, scan_y, wr_x, wr_y;
    logic [LEN_W-1:0]   cnt, check_last;
    logic               hit_nh, hit_cand, rnd_ok;

    assign game_over = (state == S_OVER);
    assign busy      = !(state inside {S_IDLE, S_WAIT, S_OVER});
    assign hit_nh    = (scan_x == nh_x) && (scan_y == nh_y);
    assign hit_cand  = (scan_x == cand_x) && (scan_y == cand_y);
    assign rnd_ok    = (rnd_x <= X_MAX) && (rnd_y <= Y_MAX);
    // When growing, the tail stays put and must be checked; at full length it drops.
    assign check_last = (eat && length != L_FULL) ? length - L_ONE : length - L_TWO;
    assign wr_x = (state == S_INIT) ? X0 - COORD_W'(cnt) : nh_x;
    assign wr_y = (state == S_INIT) ? Y0 : nh_y;

    // Next head from current head and the direction after any pending turn.
    always_comb begin
        dir_nxt = turn_pend ? rotate(dir, turn_cw) : dir;
        nx      = head_x;
        ny      = head_y;
        wall    = 1'b0;
        case (dir_nxt)
            DIR_RIGHT: if (head_x == X_MAX) begin wall = 1'b1; nx = '0;    end else nx = head_x + C_ONE;
            DIR_DOWN:  if (head_y == Y_MAX) begin wall = 1'b1; ny = '0;    end else ny = head_y + C_ONE;
            DIR_LEFT:  if (head_x == '0)    begin wall = 1'b1; nx = X_MAX; end else nx = head_x - C_ONE;
            default:   if (head_y == '0)    begin wall = 1'b1; ny = Y_MAX; end else ny = head_y - C_ONE;
        endcase
        off = wall && !WRAP;
    end

    snake_body_ring #(.COORD_W(COORD_W), .LEN_MAX(LEN_MAX), .LEN_W(LEN_W)) u_ring (
        .clock_25 (clock_25),
        .reset    (reset),
        .wr_en    (state == S_INIT),
        .wr_seg   (cnt),
        .adv      (state == S_COMMIT),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .scan_idx (cnt),
        .scan_x   (scan_x),
        .scan_y   (scan_y),
        .length   (length),
        .rd_idx   (bus.rd_idx),
        .rd_x     (bus.rd_x),
        .rd_y     (bus.rd_y),
        .rd_valid (bus.rd_valid)
    );

    // Game-flow FSM plus the tick/turn latches and all snake registers.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dir       <= DIR_RIGHT;
            turn_pend <= 1'b0;
            turn_cw   <= 1'b0;
            tik_pend  <= 1'b0;
            eat       <= 1'b0;
            cnt       <= '0;
            head_x    <= '0;
            head_y    <= '0;
            fruit_x   <= '0;
            fruit_y   <= '0;
            nh_x      <= '0;
            nh_y      <= '0;
            cand_x    <= '0;
            cand_y    <= '0;
            length    <= '0;
            score     <= '0;
        end else begin
            if (game_tik) tik_pend <= 1'b1;
            if (!turn_pend && (turn_left ^ turn_right)) begin
                turn_pend <= 1'b1;
                turn_cw   <= turn_right;
            end
            case (state)
                S_IDLE, S_OVER: if (start) begin
                    state   <= S_INIT;
                    cnt     <= '0;
                    head_x  <= X0;
                    head_y  <= Y0;
                    fruit_x <= FX0;
                    fruit_y <= Y0;
                    score   <= '0;
                    length  <= L_BEG;
                    dir     <= DIR_RIGHT;
                end
                S_INIT: begin
                    if (cnt == L_BEG - L_ONE) state <= S_WAIT;
                    else cnt <= cnt + L_ONE;
                end
                S_WAIT: if (tik_pend) begin
                    tik_pend <= game_tik;
                    state    <= S_STEP;
                end
                S_STEP: begin
                    dir       <= dir_nxt;
                    turn_pend <= turn_left ^ turn_right;
                    turn_cw   <= turn_right;
                    nh_x      <= nx;
                    nh_y      <= ny;
                    eat       <= (nx == fruit_x) && (ny == fruit_y);
                    cnt       <= '0;
                    state     <= off ? S_OVER : S_CHECK;
                end
                S_CHECK: begin
                    if (hit_nh) state <= S_OVER;
                    else if (cnt == check_last) state <= S_COMMIT;
                    else cnt <= cnt + L_ONE;
                end
                S_COMMIT: begin
                    head_x <= nh_x;
                    head_y <= nh_y;
                    if (eat) begin
                        if (length != L_FULL) length <= length + L_ONE;
                        if (score != '1) score <= score + SCORE_W'(1);
                        state <= S_SEEK;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_SEEK: begin
                    cand_x <= rnd_x;
                    cand_y <= rnd_y;
                    cnt    <= '0;
                    if (rnd_ok) state <= S_SCAN;
                end
                S_SCAN: begin
                    if (hit_cand) state <= S_SEEK;
                    else if (cnt == length - L_ONE) begin
                        fruit_x <= cand_x;
                        fruit_y <= cand_y;
                        state   <= S_WAIT;
                    end else cnt <= cnt + L_ONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed tests for snake_engine (default parameters).
module tb_snake_engine;
    import snake_pkg::*;

    localparam int COORD_W = 7;
    localparam int LEN_W   = 6;
    localparam int SCORE_W = 8;

    logic               clock_25 = 1'b0;
    logic               reset = 1'b0;
    logic               game_tik = 1'b0;
    logic               start = 1'b0;
    logic               turn_left = 1'b0;
    logic               turn_right = 1'b0;
    logic [COORD_W-1:0] rnd_x = 7'd10;
    logic [COORD_W-1:0] rnd_y = 7'd10;
    logic [COORD_W-1:0] head_x, head_y, fruit_x, fruit_y;
    logic [LEN_W-1:0]   length;
    logic [SCORE_W-1:0] score;
    logic               game_over, busy;
    state_t             state;

    int total = 0;
    int bad = 0;

    // Clock and renderer-side interface
    always #20 clock_25 = ~clock_25;

    snake_if #(.COORD_W(COORD_W), .LEN_W(LEN_W)) bus ();

    snake_engine dut (
        .clock_25   (clock_25),
        .reset      (reset),
        .game_tik   (game_tik),
        .start      (start),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .rnd_x      (rnd_x),
        .rnd_y      (rnd_y),
        .bus        (bus),
        .head_x     (head_x),
        .head_y     (head_y),
        .fruit_x    (fruit_x),
        .fruit_y    (fruit_y),
        .length     (length),
        .score      (score),
        .game_over  (game_over),
        .busy       (busy),
        .state      (state)
    );

    // Driver tasks
    task automatic cyc();
        @(negedge clock_25);
    endtask

    // Reset pulse, then start a fresh game and wait for WAIT.
    task automatic do_start();
        bit done = 0;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (state == S_WAIT) done = 1;
            else cyc();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL start_timeout state=%0d", state);
        end
    endtask

    // One move: pulse the tick, wait for the engine to go busy and return idle.
    task automatic do_tik();
        bit seen = 0;
        bit done = 0;
        game_tik = 1'b1;
        cyc();
        game_tik = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc();
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL tik_timeout state=%0d", state);
        end
    endtask

    task automatic do_turn(input logic right, input logic left);
        turn_right = right;
        turn_left  = left;
        cyc();
        turn_right = 1'b0;
        turn_left  = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b0;
        bus.rd_idx = '0;
        cyc();
        cyc();
        total++;
        if (state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
        total++;
        if ({head_x, head_y, fruit_x, fruit_y} !== '0) begin
            bad++; $display("FAIL reset_coords got=(%0d,%0d,%0d,%0d) exp=0", head_x, head_y, fruit_x, fruit_y);
        end
        total++;
        if ({length, score, game_over, busy} !== '0) begin
            bad++; $display("FAIL reset_status got=len%0d sc%0d go%0d busy%0d exp=0", length, score, game_over, busy);
        end
        total++;
        if ({bus.rd_x, bus.rd_y, bus.rd_valid} !== '0) begin
            bad++; $display("FAIL reset_rd got=(%0d,%0d,v%0d) exp=0", bus.rd_x, bus.rd_y, bus.rd_valid);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_start();
        do_start();
        total++;
        if ({head_x, head_y, fruit_x, fruit_y} !== {7'd62, 7'd40, 7'd70, 7'd40}) begin
            bad++; $display("FAIL start_pos got=(%0d,%0d) fruit=(%0d,%0d) exp=(62,40) fruit=(70,40)", head_x, head_y, fruit_x, fruit_y);
        end
        total++;
        if ({length, score, busy, game_over} !== {6'd4, 8'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL start_status got=len%0d sc%0d exp=len4 sc0", length, score);
        end
        for (int k = 0; k < 4; k++) begin
            bus.rd_idx = LEN_W'(k);
            cyc();
            total++;
            if ({bus.rd_valid, bus.rd_x, bus.rd_y} !== {1'b1, 7'(62 - k), 7'd40}) begin
                bad++; $display("FAIL start_seg%0d got=(%0d,%0d,v%0d) exp=(%0d,40,v1)", k, bus.rd_x, bus.rd_y, bus.rd_valid, 62 - k);
            end
        end
    endtask

    task automatic test_turns();
        do_start();
        do_turn(1'b1, 1'b0);
        do_tik();
        total++;
        if ({head_x, head_y} !== {7'd62, 7'd41}) begin
            bad++; $display("FAIL turn_right got=(%0d,%0d) exp=(62,41)", head_x, head_y);
        end
        do_tik();
        total++;
        if ({head_x, head_y} !== {7'd62, 7'd42}) begin
            bad++; $display("FAIL dir_down_kept got=(%0d,%0d) exp=(62,42)", head_x, head_y);
        end
        do_start();
        do_turn(1'b1, 1'b1);
        do_tik();
        total++;
        if ({head_x, head_y} !== {7'd63, 7'd40}) begin
            bad++; $display("FAIL both_turns got=(%0d,%0d) exp=(63,40)", head_x, head_y);
        end
        do_start();
        do_turn(1'b0, 1'b1);
        do_turn(1'b1, 1'b0);
        do_tik();
        total++;
        if ({head_x, head_y} !== {7'd62, 7'd39}) begin
            bad++; $display("FAIL first_turn_wins got=(%0d,%0d) exp=(62,39)", head_x, head_y);
        end
    endtask

    task automatic test_loop4();
        do_start();
        do_turn(1'b1, 1'b0); do_tik();
        do_turn(1'b1, 1'b0); do_tik();
        total++;
        if ({head_x, head_y} !== {7'd61, 7'd41}) begin
            bad++; $display("FAIL loop4_mid got=(%0d,%0d) exp=(61,41)", head_x, head_y);
        end
        do_turn(1'b1, 1'b0); do_tik();
        total++;
        if ({game_over, head_x, head_y, length} !== {1'b0, 7'd61, 7'd40, 6'd4}) begin
            bad++; $display("FAIL loop4_tail got=go%0d (%0d,%0d) len%0d exp=go0 (61,40) len4", game_over, head_x, head_y, length);
        end
    endtask

    task automatic test_eat_seek();
        int  samples = 0;
        bit  seen = 0;
        bit  done = 0;
        do_start();
        for (int i = 0; i < 7; i++) do_tik();
        rnd_x = 7'd130 & 7'h7f;
        rnd_x = 7'd127;
        rnd_y = 7'd10;
        game_tik = 1'b1;
        cyc();
        game_tik = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc();
            if (busy) seen = 1;
            else if (seen) done = 1;
            if (state == S_SEEK) begin
                samples++;
                if (samples == 1) begin rnd_x = 7'd127; rnd_y = 7'd10; end
                else if (samples == 2) begin rnd_x = 7'd68; rnd_y = 7'd40; end
                else begin rnd_x = 7'd10; rnd_y = 7'd10; end
            end
        end
        rnd_x = 7'd10;
        rnd_y = 7'd10;
        total++;
        if (!done) begin bad++; $display("FAIL eat_timeout state=%0d", state); end
        total++;
        if ({head_x, head_y, length, score} !== {7'd70, 7'd40, 6'd5, 8'd1}) begin
            bad++; $display("FAIL eat_status got=(%0d,%0d) len%0d sc%0d exp=(70,40) len5 sc1", head_x, head_y, length, score);
        end
        total++;
        if ({fruit_x, fruit_y} !== {7'd10, 7'd10}) begin
            bad++; $display("FAIL seek_fruit got=(%0d,%0d) exp=(10,10)", fruit_x, fruit_y);
        end
        total++;
        if (samples != 3) begin bad++; $display("FAIL seek_samples got=%0d exp=3", samples); end
        for (int k = 0; k < 5; k++) begin
            bus.rd_idx = LEN_W'(k);
            cyc();
            total++;
            if ({bus.rd_valid, bus.rd_x, bus.rd_y} !== {1'b1, 7'(70 - k), 7'd40}) begin
                bad++; $display("FAIL eat_seg%0d got=(%0d,%0d,v%0d) exp=(%0d,40,v1)", k, bus.rd_x, bus.rd_y, bus.rd_valid, 70 - k);
            end
        end
        bus.rd_idx = 6'd5;
        cyc();
        total++;
        if ({bus.rd_valid, bus.rd_x, bus.rd_y} !== {1'b0, 7'd66, 7'd40}) begin
            bad++; $display("FAIL rd_hold got=(%0d,%0d,v%0d) exp=(66,40,v0)", bus.rd_x, bus.rd_y, bus.rd_valid);
        end
        // Same 2x2 loop at length 5: the cell entered is not the tail.
        do_turn(1'b1, 1'b0); do_tik();
        do_turn(1'b1, 1'b0); do_tik();
        total++;
        if ({game_over, head_x, head_y} !== {1'b0, 7'd69, 7'd41}) begin
            bad++; $display("FAIL loop5_mid got=go%0d (%0d,%0d) exp=go0 (69,41)", game_over, head_x, head_y);
        end
        do_turn(1'b1, 1'b0); do_tik();
        total++;
        if ({game_over, busy, head_x, head_y} !== {1'b1, 1'b0, 7'd69, 7'd41}) begin
            bad++; $display("FAIL loop5_over got=go%0d busy%0d (%0d,%0d) exp=go1 busy0 (69,41)", game_over, busy, head_x, head_y);
        end
    endtask

    task automatic test_wall();
        do_start();
        for (int i = 0; i < 61; i++) do_tik();
        total++;
        if ({game_over, head_x, head_y, length, score} !== {1'b0, 7'd123, 7'd40, 6'd5, 8'd1}) begin
            bad++; $display("FAIL wall_edge got=go%0d (%0d,%0d) len%0d sc%0d exp=go0 (123,40) len5 sc1", game_over, head_x, head_y, length, score);
        end
        do_tik();
        total++;
`ifdef SNAKE_WRAP_EN
        if ({game_over, head_x, head_y} !== {1'b0, 7'd0, 7'd40}) begin
            bad++; $display("FAIL wall_wrap got=go%0d (%0d,%0d) exp=go0 (0,40)", game_over, head_x, head_y);
        end
`else
        if ({game_over, head_x, head_y} !== {1'b1, 7'd123, 7'd40}) begin
            bad++; $display("FAIL wall_over got=go%0d (%0d,%0d) exp=go1 (123,40)", game_over, head_x, head_y);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        bit done = 0;
        do_start();
        game_tik = 1'b1;
        cyc();
        game_tik = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (state == S_CHECK) done = 1;
        end
        total++;
        if (!done || busy !== 1'b1) begin
            bad++; $display("FAIL check_reach got=state%0d busy%0d exp=state%0d busy1", state, busy, S_CHECK);
        end
        bus.rd_idx = '0;
        reset = 1'b0;
        #1;
        total++;
        if (state !== S_IDLE || {head_x, head_y, fruit_x, fruit_y, length, score, game_over, busy} !== '0) begin
            bad++; $display("FAIL abort_async got=state%0d head=(%0d,%0d) len%0d busy%0d exp=idle zeros", state, head_x, head_y, length, busy);
        end
        cyc();
        total++;
        if (state !== S_IDLE || {bus.rd_x, bus.rd_y, bus.rd_valid, length, busy} !== '0) begin
            bad++; $display("FAIL abort_hold got=state%0d rd=(%0d,%0d,v%0d) len%0d exp=idle zeros", state, bus.rd_x, bus.rd_y, bus.rd_valid, length);
        end
        reset = 1'b1;
        cyc();
        cyc();
        total++;
        if ({state, bus.rd_valid} !== {S_IDLE, 1'b0}) begin
            bad++; $display("FAIL after_release got=state%0d v%0d exp=idle v0", state, bus.rd_valid);
        end
    endtask

    // Sequencer and final report
    initial begin
        bus.rd_idx = '0;
        test_reset();
        test_start();
        test_turns();
        test_loop4();
        test_eat_seek();
        test_wall();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
